ccff_chain_loader: RTL and testbench



---
 rtl/ccff_chain_loader.sv | 215 +++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------
// ccff_chain_loader
//
// Loads the configuration chain of one tile row. Bitstream words arrive over
// a valid/ready handshake and are shifted MSB-first into ccff_head, one bit
// per prog_clk cycle, while ccff_shift_en gates the chain's clock. A bit
// counter stops the load after exactly CHAIN_LEN shift pulses; a partial last
// word contributes only its top bits.
//
// Optional build macro: CCFF_READBACK_EN
//   When defined, a CRC-16-CCITT is accumulated over every bit sent to the
//   chain. After the load the chain is recirculated once (ccff_tail fed back
//   into ccff_head for CHAIN_LEN pulses) while a second CRC is taken over
//   ccff_tail; err is raised if the two CRCs differ.
//   When undefined, err is tied 0 and ccff_tail is unused.
//
// Ports:
//   prog_clk       in   programming clock (only clock)
//   prog_reset     in   synchronous active-high reset
//   start          in   one-cycle request to begin a full chain load
//   cfg_data       in   bitstream word, bit WORD_W-1 shifted first
//   cfg_valid      in   cfg_data valid
//   cfg_ready      out  loader accepts a word this cycle
//   ccff_head      out  serial data into the chain head
//   ccff_tail      in   serial data from the chain tail
//   ccff_shift_en  out  chain shifts at the end of this cycle
//   busy           out  load (or readback) in progress
//   done           out  chain fully loaded, held until the next start
//   err            out  readback CRC mismatch
// ---------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 4096,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int NW    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
`ifdef CCFF_READBACK_EN
        , ST_READBACK
`endif
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;   // shift pulses issued in the current pass
    logic [NW-1:0]     left_q;      // pulses still owed for the current word
    logic [WORD_W-1:0] sr_q;        // remaining bits of the word, MSB next
    logic              head_q;
    logic              shift_en_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic [NW-1:0]     n_d;         // bits to take from the word being accepted

`ifdef CCFF_READBACK_EN
    logic [15:0] crc_w_q;           // CRC over bits written into the chain
    logic [15:0] crc_r_q;           // CRC over bits read back from the tail
    logic        err_q;

    // Bit-serial CRC-16-CCITT, polynomial x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction
`endif

    // n = min(WORD_W, CHAIN_LEN - bit_cnt): the last word may be partial.
    // NOTE: both branches assign n_d, so this stays pure combinational logic
    // and no latch is inferred.
    always_comb begin
        if (CHAIN_LEN - int'(bit_cnt_q) >= WORD_W) begin
            n_d = NW'(WORD_W);
        end else begin
            n_d = NW'(CHAIN_LEN - int'(bit_cnt_q));
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            // NOTE: sr_q is pure datapath and is always rewritten on word
            // acceptance before it is used, so it is deliberately not reset.
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            left_q     <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CCFF_READBACK_EN
            crc_w_q    <= 16'hFFFF;
            crc_r_q    <= 16'hFFFF;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                // DONE is a one-cycle pass-through; busy is already low, so a
                // start arriving there is honoured just like in IDLE.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b0;
                        bit_cnt_q <= '0;
`ifdef CCFF_READBACK_EN
                        err_q     <= 1'b0;
                        crc_w_q   <= 16'hFFFF;
                        crc_r_q   <= 16'hFFFF;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_LOAD: begin
                    if (cfg_valid && ready_q) begin
                        // The MSB goes straight to the head register so the
                        // first SHIFT cycle already drives it.
                        head_q     <= cfg_data[WORD_W-1];
                        sr_q       <= {cfg_data[WORD_W-2:0], 1'b0};
                        left_q     <= n_d;
                        ready_q    <= 1'b0;
                        shift_en_q <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    head_q    <= sr_q[WORD_W-1];
                    sr_q      <= {sr_q[WORD_W-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    left_q    <= left_q - NW'(1);
`ifdef CCFF_READBACK_EN
                    crc_w_q   <= crc16_step(crc_w_q, head_q);
`endif
                    if (left_q == NW'(1)) begin
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef CCFF_READBACK_EN
                            // Keep shifting: recirculate the whole chain once.
                            bit_cnt_q <= '0;
                            state_q   <= ST_READBACK;
`else
                            shift_en_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
`endif
                        end else begin
                            shift_en_q <= 1'b0;
                            ready_q    <= 1'b1;
                            state_q    <= ST_LOAD;
                        end
                    end
                end

`ifdef CCFF_READBACK_EN
                ST_READBACK: begin
                    crc_r_q   <= crc16_step(crc_r_q, ccff_tail);
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        shift_en_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        err_q      <= (crc16_step(crc_r_q, ccff_tail) != crc_w_q);
                        state_q    <= ST_DONE;
                    end
                end
`endif

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready     = ready_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef CCFF_READBACK_EN
    // During recirculation the tail is passed straight through; a register
    // here would add a stage to the loop and rotate the chain contents.
    assign ccff_head = (state_q == ST_READBACK) ? ccff_tail : head_q;
    assign err       = err_q;
`else
    logic tail_unused;
    assign tail_unused = ccff_tail;
    assign ccff_head   = head_q;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

`ifdef CCFF_READBACK_EN
    localparam int RB_A = 70;
    localparam int RB_B = 64;
`else
    localparam int RB_A = 0;
    localparam int RB_B = 0;
`endif

    // Expected chain images: chain[L-1] is the tail-most flip-flop and holds
    // the first bit shifted, i.e. the MSB of the first word.
    localparam logic [69:0] EXP_A = {32'hDEADBEEF, 32'h12345678, 6'b111111};
    localparam logic [31:0] B_W0  = 32'hA5A50F0F;
    localparam logic [31:0] B_W1  = 32'h3C3C9669;
    localparam logic [63:0] EXP_B = {B_W0, B_W1};

    logic clk;
    int   vectors;
    int   miscompares;

    // Instance A: CHAIN_LEN=70
    logic        rst_a, start_a, valid_a, ready_a, head_a, tail_a, sen_a;
    logic        busy_a, done_a, err_a;
    logic [31:0] data_a;
    logic [69:0] chain_a, nxt_a;
    bit          stuck_a;

    // Instance B: CHAIN_LEN=64
    logic        rst_b, start_b, valid_b, ready_b, head_b, tail_b, sen_b;
    logic        busy_b, done_b, err_b;
    logic [31:0] data_b;
    logic [63:0] chain_b;

    int pulses_a, ready_cyc_a, overlap_a;
    int pulses_b, ready_cyc_b;

    ccff_chain_loader #(.CHAIN_LEN(70), .WORD_W(32)) u_dut_a (
        .prog_clk(clk), .prog_reset(rst_a), .start(start_a),
        .cfg_data(data_a), .cfg_valid(valid_a), .cfg_ready(ready_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .ccff_shift_en(sen_a),
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) u_dut_b (
        .prog_clk(clk), .prog_reset(rst_b), .start(start_b),
        .cfg_data(data_b), .cfg_valid(valid_b), .cfg_ready(ready_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .ccff_shift_en(sen_b),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural chains; optional stuck-at-0 flip-flop at index 30 of A.
    always @(posedge clk) begin
        if (sen_a) begin
            nxt_a = {chain_a[68:0], head_a};
            if (stuck_a) nxt_a[30] = 1'b0;
            chain_a <= nxt_a;
        end
        if (sen_b) chain_b <= {chain_b[62:0], head_b};
    end
    assign tail_a = chain_a[69];
    assign tail_b = chain_b[63];

    // Event monitors (only ever incremented; tests work on differences).
    always @(posedge clk) begin
        if (sen_a) pulses_a++;
        if (ready_a) ready_cyc_a++;
        if (sen_a && ready_a) overlap_a++;
        if (sen_b) pulses_b++;
        if (ready_b) ready_cyc_b++;
    end

    task automatic wait_ready_a(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: cfg_ready timeout, got 0 required 1", name);
        end
    endtask

    task automatic wait_done_a(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: done timeout, got 0 required 1", name);
        end
    endtask

    // Feeds the three A words; valid stays high except during back-pressure.
    task automatic feed_a(input string name, input bit bp, input bit noise);
        logic [31:0] w [3];
        int p0;
        w = '{32'hDEADBEEF, 32'h12345678, 32'hFC000000};
        for (int k = 0; k < 3; k++) begin
            wait_ready_a(name);
            if (bp && k == 1) begin
                valid_a = 1'b0;
                p0 = pulses_a;
                repeat (5) @(negedge clk);
                vectors++;
                if ({ready_a, sen_a} !== 2'b10) begin
                    miscompares++;
                    $display("FAIL %s bp_hold: ready,shift_en got %b required 10", name, {ready_a, sen_a});
                end
                vectors++;
                if (pulses_a - p0 !== 0) begin
                    miscompares++;
                    $display("FAIL %s bp_pulses: got %0d required 0", name, pulses_a - p0);
                end
            end
            data_a  = w[k];
            valid_a = 1'b1;
            @(negedge clk);
            if (noise) begin
                data_a = 32'hFFFFFFFF;
                if (k == 0) begin
                    repeat (4) @(negedge clk);
                    start_a = 1'b1;
                    @(negedge clk);
                    start_a = 1'b0;
                end
            end
        end
    endtask

    task automatic run_load_a(input string name, input bit bp, input bit noise,
                              input bit check_chain, input logic exp_err);
        int p0, r0, o0;
        p0 = pulses_a;
        r0 = ready_cyc_a;
        o0 = overlap_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        vectors++;
        if ({busy_a, ready_a, done_a, err_a} !== 4'b1100) begin
            miscompares++;
            $display("FAIL %s start: busy,ready,done,err got %b required 1100", name,
                     {busy_a, ready_a, done_a, err_a});
        end
        feed_a(name, bp, noise);
        wait_done_a(name);
        vectors++;
        if (pulses_a - p0 !== 70 + RB_A) begin
            miscompares++;
            $display("FAIL %s pulses: got %0d required %0d", name, pulses_a - p0, 70 + RB_A);
        end
        vectors++;
        if (ready_cyc_a - r0 !== (bp ? 8 : 3)) begin
            miscompares++;
            $display("FAIL %s load_cycles: got %0d required %0d", name, ready_cyc_a - r0, bp ? 8 : 3);
        end
        vectors++;
        if (overlap_a - o0 !== 0) begin
            miscompares++;
            $display("FAIL %s ready_during_shift: got %0d required 0", name, overlap_a - o0);
        end
        if (check_chain) begin
            vectors++;
            if (chain_a !== EXP_A) begin
                miscompares++;
                $display("FAIL %s chain: got %h required %h", name, chain_a, EXP_A);
            end
        end
        vectors++;
        if ({busy_a, sen_a, ready_a, done_a} !== 4'b0001) begin
            miscompares++;
            $display("FAIL %s finish: busy,shift_en,ready,done got %b required 0001", name,
                     {busy_a, sen_a, ready_a, done_a});
        end
        vectors++;
        if (err_a !== exp_err) begin
            miscompares++;
            $display("FAIL %s err: got %b required %b", name, err_a, exp_err);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_a !== 1'b1 || pulses_a - p0 !== 70 + RB_A) begin
            miscompares++;
            $display("FAIL %s done_hold: done %b pulses %0d required 1 and %0d", name,
                     done_a, pulses_a - p0, 70 + RB_A);
        end
    endtask

    task automatic test_reset;
        vectors++;
        if ({ready_a, head_a, sen_a, busy_a, done_a, err_a} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_a: outputs got %b required 000000",
                     {ready_a, head_a, sen_a, busy_a, done_a, err_a});
        end
        vectors++;
        if ({ready_b, head_b, sen_b, busy_b, done_b, err_b} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_b: outputs got %b required 000000",
                     {ready_b, head_b, sen_b, busy_b, done_b, err_b});
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load;
        run_load_a("basic", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure;
        run_load_a("backpressure", 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        run_load_a("ignored_inputs", 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midload;
        int  p0;
        bit  ok;
        p0 = pulses_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_ready_a("reset_midload");
        data_a  = 32'hDEADBEEF;
        valid_a = 1'b1;
        @(negedge clk);
        wait_ready_a("reset_midload");
        data_a = 32'h12345678;
        @(negedge clk);
        // Assert reset while pulse 40 is in flight; it is the last one.
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pulses_a - p0 == 39) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reset_midload: pulse 39 timeout, got %0d required 39", pulses_a - p0);
        end
        rst_a = 1'b1;
        @(negedge clk);
        vectors++;
        if ({ready_a, head_a, sen_a, busy_a, done_a, err_a} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_midload outputs: got %b required 000000",
                     {ready_a, head_a, sen_a, busy_a, done_a, err_a});
        end
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (pulses_a - p0 !== 40 || done_a !== 1'b0 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midload after: pulses %0d done %b busy %b required 40 0 0",
                     pulses_a - p0, done_a, busy_a);
        end
        run_load_a("reload_after_reset", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_exact_multiple;
        logic [31:0] w [2];
        int  p0, r0;
        bit  ok;
        w  = '{B_W0, B_W1};
        p0 = pulses_b;
        r0 = ready_cyc_b;
        valid_b = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (ready_b) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL exact_multiple: cfg_ready timeout word %0d, got 0 required 1", k);
            end
            data_b = w[k];
            @(negedge clk);
        end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done_b) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL exact_multiple: done timeout, got 0 required 1");
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (pulses_b - p0 !== 64 + RB_B) begin
            miscompares++;
            $display("FAIL exact_multiple pulses: got %0d required %0d", pulses_b - p0, 64 + RB_B);
        end
        vectors++;
        if (ready_cyc_b - r0 !== 2) begin
            miscompares++;
            $display("FAIL exact_multiple load_cycles: got %0d required 2", ready_cyc_b - r0);
        end
        vectors++;
        if (chain_b !== EXP_B) begin
            miscompares++;
            $display("FAIL exact_multiple chain: got %h required %h", chain_b, EXP_B);
        end
        vectors++;
        if ({busy_b, done_b, err_b} !== 3'b010) begin
            miscompares++;
            $display("FAIL exact_multiple finish: busy,done,err got %b required 010",
                     {busy_b, done_b, err_b});
        end
    endtask

`ifdef CCFF_READBACK_EN
    task automatic test_readback_stuck;
        stuck_a = 1'b1;
        run_load_a("readback_stuck", 1'b0, 1'b0, 1'b0, 1'b1);
        stuck_a = 1'b0;
        run_load_a("readback_clean", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        stuck_a     = 1'b0;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        start_a     = 1'b0;
        start_b     = 1'b0;
        valid_a     = 1'b0;
        valid_b     = 1'b0;
        data_a      = '0;
        data_b      = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic_load();
        test_backpressure();
        test_ignored_inputs();
        test_reset_midload();
        test_exact_multiple();
`ifdef CCFF_READBACK_EN
        test_readback_stuck();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
